// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-ported core memory between the instruction-fetch
//   requester (IF) and the load/store requester (DATA). It grants with
//   round-robin priority, counts out the fixed memory read latency, and
//   answers illegal accesses (misaligned, bad size, store into instruction
//   space) itself, without touching the memory.
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   if_req/if_addr      IF request (always a word load)
//   if_gnt/if_rvalid    IF accept pulse / response pulse
//   if_rdata/if_err     IF response data / rejection flag
//   d_req/d_we/d_addr/d_wdata/d_size/d_sz_ex   DATA request payload
//   d_gnt/d_rvalid/d_rdata/d_err               DATA handshake and response
//   mem_wr_en/mem_address/mem_in_data/mem_size/mem_sz_ex   memory request
//   mem_out_data        memory read data
//   busy                high whenever the sequencer is not idle
module mem_port_arbiter #(
  parameter int BUS_WIDTH  = 32,
  parameter int MEM_LAT    = 2,
  parameter int I_MEM_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [BUS_WIDTH-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [BUS_WIDTH-1:0] if_rdata,
  output logic                 if_err,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [BUS_WIDTH-1:0] d_addr,
  input  logic [BUS_WIDTH-1:0] d_wdata,
  input  logic [1:0]           d_size,
  input  logic                 d_sz_ex,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [BUS_WIDTH-1:0] d_rdata,
  output logic                 d_err,
  output logic                 mem_wr_en,
  output logic [BUS_WIDTH-1:0] mem_address,
  output logic [BUS_WIDTH-1:0] mem_in_data,
  output logic [1:0]           mem_size,
  output logic                 mem_sz_ex,
  input  logic [BUS_WIDTH-1:0] mem_out_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [BUS_WIDTH-1:0] I_MEM_LIM = BUS_WIDTH'(I_MEM_SIZE);
  localparam logic [3:0]           CNT_INIT  = 4'(MEM_LAT - 1);

  // Illegal: size 11, misaligned half/word, or DATA store into instruction space.
  function automatic logic access_illegal(input logic                 is_if,
                                          input logic                 we,
                                          input logic [BUS_WIDTH-1:0] addr,
                                          input logic [1:0]           size);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
      2'b10:   bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    bad = bad | (!is_if && we && (addr < I_MEM_LIM));
    return bad;
  endfunction

  state_t               state_q;
  logic [3:0]           cnt_q;
  logic                 last_if_q;   // 1: IF was served last, 0: DATA
  logic                 sel_if_q;    // winner of the access in flight
  logic                 we_q;
  logic                 if_gnt_q, if_rvalid_q, if_err_q;
  logic                 d_gnt_q, d_rvalid_q, d_err_q;
  logic [BUS_WIDTH-1:0] if_rdata_q, d_rdata_q;
  logic                 mem_wr_en_q, mem_sz_ex_q;
  logic [BUS_WIDTH-1:0] mem_address_q, mem_in_data_q;
  logic [1:0]           mem_size_q;
  logic                 busy_q;

  logic                 sample_s;
  logic                 pick_if_s;
  logic                 bad_s;
  logic                 we_d, sz_ex_d;
  logic [BUS_WIDTH-1:0] addr_d, wdata_d;
  logic [1:0]           size_d;

  // Requests are only looked at in IDLE and RESP.
  assign sample_s = (state_q == S_IDLE) || (state_q == S_RESP);

  // Round-robin pick and the payload that would be latched for the winner.
  always_comb begin
    pick_if_s = 1'b0;
    addr_d    = '0;
    wdata_d   = '0;
    we_d      = 1'b0;
    size_d    = 2'b10;
    sz_ex_d   = 1'b0;
    if (if_req && (!d_req || !last_if_q)) begin
      pick_if_s = 1'b1;
      addr_d    = if_addr;
      wdata_d   = '0;
      we_d      = 1'b0;
      size_d    = 2'b10;
      sz_ex_d   = 1'b0;
    end else begin
      pick_if_s = 1'b0;
      addr_d    = d_addr;
      wdata_d   = d_wdata;
      we_d      = d_we;
      size_d    = d_size;
      sz_ex_d   = d_sz_ex;
    end
    bad_s = access_illegal(pick_if_s, we_d, addr_d, size_d);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      last_if_q     <= 1'b0;
      sel_if_q      <= 1'b0;
      we_q          <= 1'b0;
      if_gnt_q      <= 1'b0;
      if_rvalid_q   <= 1'b0;
      if_err_q      <= 1'b0;
      if_rdata_q    <= '0;
      d_gnt_q       <= 1'b0;
      d_rvalid_q    <= 1'b0;
      d_err_q       <= 1'b0;
      d_rdata_q     <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_address_q <= '0;
      mem_in_data_q <= '0;
      mem_size_q    <= 2'b00;
      mem_sz_ex_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      mem_wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_RESP: begin
          if_rvalid_q <= 1'b0;
          d_rvalid_q  <= 1'b0;
          if_err_q    <= 1'b0;
          d_err_q     <= 1'b0;
          if (sample_s && (if_req || d_req)) begin
            sel_if_q  <= pick_if_s;
            last_if_q <= pick_if_s;
            we_q      <= we_d;
            if_gnt_q  <= pick_if_s;
            d_gnt_q   <= !pick_if_s;
            busy_q    <= 1'b1;
            if (bad_s) begin
              // Rejected: answer at once, memory is never driven.
              state_q <= S_RESP;
              if (pick_if_s) begin
                if_rvalid_q <= 1'b1;
                if_err_q    <= 1'b1;
                if_rdata_q  <= '0;
              end else begin
                d_rvalid_q <= 1'b1;
                d_err_q    <= 1'b1;
                d_rdata_q  <= '0;
              end
            end else begin
              state_q       <= S_ISSUE;
              mem_wr_en_q   <= we_d;
              mem_address_q <= addr_d;
              mem_in_data_q <= wdata_d;
              mem_size_q    <= size_d;
              mem_sz_ex_q   <= sz_ex_d;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          cnt_q   <= CNT_INIT;
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
            // Stores are acknowledged with zero data.
            if (sel_if_q) begin
              if_rvalid_q <= 1'b1;
              if_err_q    <= 1'b0;
              if_rdata_q  <= we_q ? '0 : mem_out_data;
            end else begin
              d_rvalid_q <= 1'b1;
              d_err_q    <= 1'b0;
              d_rdata_q  <= we_q ? '0 : mem_out_data;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt      = if_gnt_q;
  assign if_rvalid   = if_rvalid_q;
  assign if_rdata    = if_rdata_q;
  assign if_err      = if_err_q;
  assign d_gnt       = d_gnt_q;
  assign d_rvalid    = d_rvalid_q;
  assign d_rdata     = d_rdata_q;
  assign d_err       = d_err_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_address = mem_address_q;
  assign mem_in_data = mem_in_data_q;
  assign mem_size    = mem_size_q;
  assign mem_sz_ex   = mem_sz_ex_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, I_MEM_SIZE=32).
// The memory is a combinational lookup: address 0x4 returns 0x00A00093,
// any other address returns address ^ 0xC0DE0000.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_sz_ex;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_size;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_wr_en, mem_sz_ex;
  logic [31:0] mem_address, mem_in_data, mem_out_data;
  logic [1:0]  mem_size;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  int          wr_cnt = 0;
  logic [31:0] wr_addr = 32'd0;
  logic [31:0] wr_data = 32'd0;

  mem_port_arbiter #(.BUS_WIDTH(32), .MEM_LAT(2), .I_MEM_SIZE(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_sz_ex(d_sz_ex), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_wr_en(mem_wr_en), .mem_address(mem_address),
    .mem_in_data(mem_in_data), .mem_size(mem_size), .mem_sz_ex(mem_sz_ex),
    .mem_out_data(mem_out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_out_data = (mem_address == 32'h4) ? 32'h00A00093
                                               : (mem_address ^ 32'hC0DE0000);

  // Record every cycle the memory write enable is seen high.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_address;
      wr_data <= mem_in_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0; if_addr = 32'd0;
    d_req   = 1'b0; d_we    = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    d_size  = 2'b10; d_sz_ex = 1'b0;
  endtask

  // One-cycle rejected request: gnt, rvalid and err together, rdata cleared.
  task automatic illegal_d(input string tag, input logic we, input logic [31:0] addr,
                           input logic [1:0] size);
    int w0;
    w0 = wr_cnt;
    d_req = 1'b1; d_we = we; d_addr = addr; d_size = size; d_wdata = 32'h55AA55AA;
    step();
    chk({tag, "_gnt_rv_err"}, 32'({d_gnt, d_rvalid, d_err, if_gnt, if_rvalid}), 32'b11100);
    chk({tag, "_rdata"}, d_rdata, 32'd0);
    d_req = 1'b0;
    step();
    chk({tag, "_after"}, 32'({d_rvalid, d_err, busy}), 32'd0);
    chk({tag, "_nowr"}, 32'(wr_cnt - w0), 32'd0);
  endtask

  logic [15:0] ig, dg, iv, dv, bz;
  int w0;

  initial begin
    idle_inputs();
    rst = 1'b0;
    step(); step();
    chk("rst_ctrl", 32'({if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err,
                         mem_wr_en, mem_sz_ex, busy}), 32'd0);
    chk("rst_buses", if_rdata | d_rdata | mem_address | mem_in_data | 32'(mem_size), 32'd0);
    rst = 1'b1;
    step();

    // IF word read at 0x4.
    w0 = wr_cnt;
    if_req = 1'b1; if_addr = 32'h4;
    step();
    chk("if_gnt", 32'({if_gnt, d_gnt, if_rvalid, busy}), 32'b1001);
    chk("if_addr", mem_address, 32'h4);
    if_req = 1'b0;
    step();
    chk("if_wait1", 32'({if_gnt, if_rvalid}), 32'd0);
    step();
    chk("if_wait2", 32'(if_rvalid), 32'd0);
    step();
    chk("if_rv", 32'({if_rvalid, if_err}), 32'b10);
    chk("if_rdata", if_rdata, 32'h00A00093);
    step();
    chk("if_done", 32'({if_rvalid, busy}), 32'd0);
    chk("if_nowr", 32'(wr_cnt - w0), 32'd0);

    // DATA word store to 0x44.
    w0 = wr_cnt;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'hDEADBEEF; d_size = 2'b10;
    step();
    chk("st_gnt", 32'({d_gnt, mem_wr_en}), 32'b11);
    d_req = 1'b0;
    step(); step(); step();
    chk("st_rv", 32'({d_rvalid, d_err}), 32'b10);
    chk("st_rdata", d_rdata, 32'd0);
    step();
    chk("st_wrcnt", 32'(wr_cnt - w0), 32'd1);
    chk("st_wraddr", wr_addr, 32'h44);
    chk("st_wrdata", wr_data, 32'hDEADBEEF);

    // Tie: DATA was served last, so order is IF, DATA, IF, back to back.
    if_req = 1'b1; if_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_size = 2'b10; d_wdata = 32'd0;
    ig = 16'd0; dg = 16'd0; iv = 16'd0; dv = 16'd0; bz = 16'd0;
    for (int c = 1; c <= 13; c++) begin
      step();
      ig[c] = if_gnt; dg[c] = d_gnt; iv[c] = if_rvalid; dv[c] = d_rvalid; bz[c] = busy;
      if (c == 11) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
    end
    chk("tie_if_gnt", 32'(ig), 32'h0202);
    chk("tie_d_gnt", 32'(dg), 32'h0020);
    chk("tie_if_rv", 32'(iv), 32'h1010);
    chk("tie_d_rv", 32'(dv), 32'h0100);
    chk("tie_busy", 32'(bz), 32'h1FFE);
    chk("tie_if_rdata", if_rdata, 32'hC0DE0008);
    chk("tie_d_rdata", d_rdata, 32'hC0DE0040);

    // Illegal accesses.
    illegal_d("st_imem", 1'b1, 32'h10, 2'b10);
    illegal_d("half_mis", 1'b0, 32'h41, 2'b01);
    illegal_d("size11", 1'b0, 32'h40, 2'b11);
    w0 = wr_cnt;
    if_req = 1'b1; if_addr = 32'h6;
    step();
    chk("if_mis_gnt_rv_err", 32'({if_gnt, if_rvalid, if_err, d_gnt, d_rvalid}), 32'b11100);
    chk("if_mis_rdata", if_rdata, 32'd0);
    if_req = 1'b0;
    step();
    chk("if_mis_after", 32'({if_rvalid, if_err, busy, wr_cnt != w0}), 32'd0);

    // Byte load with sign extension at 0x43.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h43; d_size = 2'b00; d_sz_ex = 1'b1;
    step();
    chk("byte_gnt", 32'(d_gnt), 32'd1);
    d_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("byte_mem", 32'({mem_address[7:0], mem_size, mem_sz_ex}), 32'({8'h43, 2'b00, 1'b1}));
      if (c < 4) step();
    end
    chk("byte_rv", 32'({d_rvalid, d_err}), 32'b10);
    chk("byte_rdata", d_rdata, 32'hC0DE0043);
    d_sz_ex = 1'b0; d_size = 2'b10;
    step();

    // Reset during the WAIT of a store.
    w0 = wr_cnt;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h48; d_wdata = 32'h12345678;
    step();
    d_req = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("rst_mid_ctrl", 32'({mem_wr_en, busy, d_rvalid, d_gnt, d_err}), 32'd0);
    chk("rst_mid_bus", mem_address | mem_in_data | d_rdata | if_rdata, 32'd0);
    step(); step();
    chk("rst_mid_norv", 32'({d_rvalid, if_rvalid}), 32'd0);
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'hC;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    step();
    chk("rst_tie_if", 32'({if_gnt, d_gnt}), 32'b10);
    if_req = 1'b0; d_req = 1'b0;
    step(); step(); step();
    chk("rst_tie_rv", 32'({if_rvalid, d_rvalid}), 32'b10);
    chk("rst_tie_rdata", if_rdata, 32'hC0DE000C);
    step();
    chk("rst_wrcnt", 32'(wr_cnt - w0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
